audio_pdm_dac: RTL and testbench

//  Sink end of the synth audio path: accepts 16-bit unsigned mix samples over a valid/ready

---
 rtl/audio_pkg.sv | 16 +
 rtl/sigma_delta_mod.sv | 40 ++++
 rtl/audio_pdm_dac.sv | 141 ++++++++++++++
 tb/tb_audio_pdm_dac.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared audio-path constants and sample type, used by the
//                oscillator, the mixer and the PDM DAC sink.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    // Width of one unsigned audio sample across the whole synth path
    localparam int SAMPLE_W = 16;

    typedef logic [SAMPLE_W-1:0] sample_t;

endpackage
`default_nettype wire

// File: rtl/sigma_delta_mod.sv
`default_nettype none
// ============================================================================
//  Module      : sigma_delta_mod
//  Description : First-order sigma-delta modulator. On every strobe the
//                current sample is added to the accumulator; the carry out
//                becomes the registered 1-bit PDM output.
//  Revision    : 1.0 - initial release
// ============================================================================
module sigma_delta_mod
    import audio_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    strobe,
    input  sample_t current,
    output logic    pdm
);

    sample_t             r_acc;
    logic                r_pdm;
    logic [SAMPLE_W:0]   w_sum;

    // One extra bit so the carry is the density-encoded output bit
    assign w_sum = {1'b0, r_acc} + {1'b0, current};

    // Accumulator and output flop advance only on modulator strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_pdm <= 1'b0;
        end else if (strobe) begin
            r_acc <= w_sum[SAMPLE_W-1:0];
            r_pdm <= w_sum[SAMPLE_W];
        end
    end

    assign pdm = r_pdm;

endmodule
`default_nettype wire

// File: rtl/audio_pdm_dac.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pdm_dac
//  Description : Audio sink. Buffers samples in a 2-entry FIFO, consumes one
//                per sample period, and drives a 1-bit PDM pin through a
//                first-order sigma-delta modulator. Counts underruns.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_pdm_dac
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 1024,
    parameter int PDM_DIV = 1
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  sample_t    sample_in,
    input  logic       sample_valid,
    output logic       sample_ready,
    output logic       sample_tick,
    output logic       underrun,
    output logic [7:0] underrun_count,
    output logic       pdm_out
);

    localparam int c_TMR_W = $clog2(CLK_DIV);
    localparam int c_PDM_W = (PDM_DIV > 1) ? $clog2(PDM_DIV) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(CLK_DIV - 1);
    localparam logic [c_PDM_W-1:0] c_PDM_LAST = c_PDM_W'(PDM_DIV - 1);

    // FIFO state
    sample_t            r_mem [2];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_count;
    logic               r_ready;

    // Timing and output state
    logic [c_TMR_W-1:0] r_timer;
    logic [c_PDM_W-1:0] r_pdm_cnt;
    sample_t            r_current;
    logic [7:0]         r_ucnt;

    logic               w_tick;
    logic               w_push;
    logic               w_pop;
    logic               w_underrun;
    logic               w_strobe;
    logic               w_mod_rst;
    logic [1:0]         w_count_nxt;

    assign w_tick      = enable && (r_timer == c_TMR_LAST);
    // Ready is the registered not-full flag, so a full buffer never takes a
    // push even if a pop happens in the same cycle
    assign w_push      = sample_valid && r_ready;
    // Pop sees only the registered occupancy: no same-cycle bypass
    assign w_pop       = w_tick && (r_count != 2'd0);
    assign w_underrun  = w_tick && (r_count == 2'd0);
    assign w_strobe    = enable && (r_pdm_cnt == c_PDM_LAST);
    assign w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);
    // Idle clears the modulator exactly as reset does
    assign w_mod_rst   = rst || !enable;

    // FIFO storage, pointers, occupancy and registered ready flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= sample_in;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != 2'd2);
        end
    end

    // Sample-period timer, held at zero while idle
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_timer <= '0;
        end else if (w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + c_TMR_W'(1);
        end
    end

    // Current sample register loads the FIFO head on each non-empty tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_current <= '0;
        end else if (w_pop) begin
            r_current <= r_mem[r_rd_ptr];
        end
    end

    // Saturating underrun counter, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ucnt <= 8'd0;
        end else if (w_underrun && (r_ucnt != 8'hFF)) begin
            r_ucnt <= r_ucnt + 8'd1;
        end
    end

    // Free-running modulator divider, held at zero while idle
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_pdm_cnt <= '0;
        end else if (w_strobe) begin
            r_pdm_cnt <= '0;
        end else begin
            r_pdm_cnt <= r_pdm_cnt + c_PDM_W'(1);
        end
    end

    sigma_delta_mod u_mod (
        .clk     (clk),
        .rst     (w_mod_rst),
        .strobe  (w_strobe),
        .current (r_current),
        .pdm     (pdm_out)
    );

    assign sample_ready   = r_ready;
    assign sample_tick    = w_tick;
    assign underrun       = w_underrun;
    assign underrun_count = r_ucnt;

endmodule
`default_nettype wire

// File: tb/tb_audio_pdm_dac.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_pdm_dac
//  Description : Directed self-checking bench for audio_pdm_dac. Inputs are
//                driven and outputs observed on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_pdm_dac;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Main instance: CLK_DIV=1024, PDM_DIV=1
    logic        d_en = 1'b0, d_valid = 1'b0;
    logic [15:0] d_data = 16'h0;
    logic        d_ready, d_tick, d_ur, d_pdm;
    logic [7:0]  d_cnt;

    // Fast-period instance for underrun saturation and full-scale density
    logic        f_en = 1'b0, f_valid = 1'b0;
    logic [15:0] f_data = 16'h0;
    logic        f_ready, f_tick, f_ur, f_pdm;
    logic [7:0]  f_cnt;

    // Instance with a slowed modulator strobe
    logic        v_en = 1'b0, v_valid = 1'b0;
    logic [15:0] v_data = 16'h0;
    logic        v_ready, v_tick, v_ur, v_pdm;
    logic [7:0]  v_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    audio_pdm_dac #(.CLK_DIV(1024), .PDM_DIV(1)) u_dut (
        .clk(clk), .rst(rst), .enable(d_en), .sample_in(d_data),
        .sample_valid(d_valid), .sample_ready(d_ready), .sample_tick(d_tick),
        .underrun(d_ur), .underrun_count(d_cnt), .pdm_out(d_pdm)
    );

    audio_pdm_dac #(.CLK_DIV(4), .PDM_DIV(1)) u_fast (
        .clk(clk), .rst(rst), .enable(f_en), .sample_in(f_data),
        .sample_valid(f_valid), .sample_ready(f_ready), .sample_tick(f_tick),
        .underrun(f_ur), .underrun_count(f_cnt), .pdm_out(f_pdm)
    );

    audio_pdm_dac #(.CLK_DIV(8), .PDM_DIV(3)) u_div (
        .clk(clk), .rst(rst), .enable(v_en), .sample_in(v_data),
        .sample_valid(v_valid), .sample_ready(v_ready), .sample_tick(v_tick),
        .underrun(v_ur), .underrun_count(v_cnt), .pdm_out(v_pdm)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until(input int target);
        while (cyc < target) step();
    endtask

    // Push one sample into the main instance, waiting (bounded) for ready
    task automatic push_d(input logic [15:0] v);
        int guard;
        guard = 0;
        while (!d_ready && guard < 5000) begin
            step();
            guard++;
        end
        if (!d_ready) check("push_timeout", 32'(d_ready), 32'd1);
        d_data  = v;
        d_valid = 1'b1;
        step();
        d_valid = 1'b0;
    endtask

    initial begin
        int t0, t1, r0, first, ones, idx, ur_seen, toggles;
        int ones_a, ones_b, ones_c;
        logic rdy, prev;
        logic [15:0] vals [3];

        // ---------------- Reset values --------------------------------
        repeat (3) step();
        check("rst_pdm",    32'(d_pdm),   32'd0);
        check("rst_ready",  32'(d_ready), 32'd0);
        check("rst_tick",   32'(d_tick),  32'd0);
        check("rst_ur",     32'(d_ur),    32'd0);
        check("rst_count",  32'(d_cnt),   32'd0);
        rst = 1'b0;
        step();
        check("ready_after_rst", 32'(d_ready), 32'd1);

        // ---------------- Half scale: alternating output --------------
        push_d(16'h8000);
        d_en = 1'b1;
        t0 = cyc;
        first = -1;
        ones = 0;
        for (int j = 1; j <= 2049; j++) begin
            step();
            if (d_tick && first < 0) first = j;
            if (j == 1023) check("t2_no_ur_first_tick", 32'(d_ur), 32'd0);
            if (j == 1026) check("t2_pdm_first_one", 32'(d_pdm), 32'd1);
            if (j == 1027) check("t2_pdm_then_zero", 32'(d_pdm), 32'd0);
            if (j == 2047) check("t2_underrun_pulse", 32'(d_ur), 32'd1);
            if (j == 2048) check("t2_ucount_one", 32'(d_cnt), 32'd1);
            if (j >= 1026) ones += int'(d_pdm);
        end
        check("t2_first_tick_cycle", 32'(first), 32'd1023);
        check("t2_ones_per_1024", 32'(ones), 32'd512);

        // ---------------- Silence: output stays low -------------------
        push_d(16'h0000);
        run_until(t0 + 3073);
        ones = 0;
        for (int j = 0; j < 1024; j++) begin
            step();
            ones += int'(d_pdm);
        end
        check("t3_zero_density", 32'(ones), 32'd0);

        // ---------------- Buffer fill while idle, ordered pops --------
        vals[0] = 16'h4000;
        vals[1] = 16'hC000;
        vals[2] = 16'h8000;
        d_en = 1'b0;
        step();
        check("t4_idle_pdm", 32'(d_pdm), 32'd0);
        idx     = 0;
        d_data  = vals[0];
        d_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rdy = d_ready;
            step();
            if (rdy && d_valid) begin
                idx++;
                if (idx < 3) d_data = vals[idx];
                else d_valid = 1'b0;
            end
        end
        check("t4_ready_full", 32'(d_ready), 32'd0);
        check("t4_accepted_two", 32'(idx), 32'd2);
        d_en = 1'b1;
        t1 = cyc;
        ones_a = 0; ones_b = 0; ones_c = 0;
        for (int j = 1; j <= 4096; j++) begin
            rdy = d_ready;
            step();
            if (rdy && d_valid) begin
                idx++;
                d_valid = 1'b0;
            end
            if (j == 1022) check("t4_no_early_tick", 32'(d_tick), 32'd0);
            if (j == 1023) check("t4_tick", 32'(d_tick), 32'd1);
            if (j == 1023) check("t4_ready_at_tick", 32'(d_ready), 32'd0);
            if (j == 1024) check("t4_ready_after_pop", 32'(d_ready), 32'd1);
            if (j >= 1025 && j <= 2048) ones_a += int'(d_pdm);
            if (j >= 2049 && j <= 3072) ones_b += int'(d_pdm);
            if (j >= 3073 && j <= 4096) ones_c += int'(d_pdm);
        end
        check("t4_third_accepted", 32'(idx), 32'd3);
        check("t4_first_density", 32'(ones_a), 32'd256);
        check("t4_second_density", 32'(ones_b), 32'd768);
        check("t4_third_density", 32'(ones_c), 32'd512);
        check("t4_ucount_three", 32'(d_cnt), 32'd3);

        // ---------------- Reset mid-period with a full buffer ---------
        push_d(16'hFFFF);
        push_d(16'hFFFF);
        run_until(t1 + 4095 + 500);
        check("t6_full_before_rst", 32'(d_ready), 32'd0);
        d_data  = 16'h1234;
        d_valid = 1'b1;
        rst     = 1'b1;
        step();
        rst     = 1'b0;
        d_valid = 1'b0;
        check("t6_pdm_cleared", 32'(d_pdm), 32'd0);
        check("t6_count_cleared", 32'(d_cnt), 32'd0);
        check("t6_ready_cleared", 32'(d_ready), 32'd0);
        r0 = cyc;
        first = -1;
        ones = 0;
        ur_seen = 0;
        for (int j = 1; j <= 1100; j++) begin
            step();
            if (d_tick && first < 0) begin
                first = j;
                ur_seen = int'(d_ur);
            end
            if (j == 1) check("t6_ready_back", 32'(d_ready), 32'd1);
            ones += int'(d_pdm);
        end
        check("t6_next_tick", 32'(first), 32'd1023);
        check("t6_flushed_underrun", 32'(ur_seen), 32'd1);
        check("t6_count_after", 32'(d_cnt), 32'd1);
        check("t6_pdm_silent", 32'(ones), 32'd0);

        // ---------------- Underrun saturation, full-scale density -----
        f_data  = 16'hFFFF;
        f_valid = 1'b1;
        step();
        f_valid = 1'b0;
        f_en    = 1'b1;
        ur_seen = 0;
        ones    = 0;
        for (int j = 1; j <= 4100; j++) begin
            step();
            if (j <= 1203) ur_seen += int'(f_ur);
            if (j == 1204) check("t5_count_sat", 32'(f_cnt), 32'd255);
            if (j >= 5) ones += int'(f_pdm);
        end
        check("t5_underrun_pulses", 32'(ur_seen), 32'd300);
        check("t5_count_held", 32'(f_cnt), 32'd255);
        check("t5_fullscale_ones", 32'(ones), 32'd4095);

        // ---------------- Divided modulator strobe --------------------
        v_data  = 16'h8000;
        v_valid = 1'b1;
        step();
        v_valid = 1'b0;
        v_en    = 1'b1;
        first   = -1;
        ones    = 0;
        toggles = 0;
        prev    = 1'b0;
        for (int j = 1; j <= 640; j++) begin
            step();
            if (v_tick && first < 0) first = j;
            if (j >= 41) begin
                ones += int'(v_pdm);
                if (v_pdm != prev) toggles++;
            end
            prev = v_pdm;
        end
        check("t7_first_tick", 32'(first), 32'd7);
        check("t7_ones", 32'(ones), 32'd300);
        check("t7_toggles", 32'(toggles), 32'd200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
